// File: rtl/ana_scan_pkg.sv
// ============================================================================
//  Module   : ana_scan_pkg
//  Purpose  : Shared types, select-code constants and channel picker for the
//             analog mux scan master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ana_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_WRITE    = 3'd2,
        S_SETTLE   = 3'd3,
        S_CONVERT  = 3'd4,
        S_RESULT   = 3'd5,
        S_DESELECT = 3'd6,
        S_DONE     = 3'd7
    } scan_state_e;

    localparam int         SEL_EN_BIT    = 3;
    localparam logic [3:0] SEL_DESELECT  = 4'h0;
    localparam int         SEL_BASE_CHAN = 17;

    typedef struct packed {
        logic       found;
        logic [2:0] ch;
    } pick_t;

    // Lowest enabled channel at or above 'from'; from=8 always yields none.
    function automatic pick_t next_chan(input logic [7:0] mask, input logic [3:0] from);
        pick_t p;
        p.found = 1'b0;
        p.ch    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                p.found = 1'b1;
                p.ch    = 3'(i);
            end
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ana_scan_timer.sv
// ============================================================================
//  Module   : ana_scan_timer
//  Purpose  : Loadable down-counter with a zero flag, used for settle and
//             conversion-timeout intervals.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ana_scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/ana_mux_scan_master.sv
// ============================================================================
//  Module   : ana_mux_scan_master
//  Purpose  : Avalon-MM write-only master stepping the analog mux select PIO
//             through channels 17-24 and sequencing one ADC conversion each.
//             Define ANA_SCAN_TIMEOUT_EN to add the conversion timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ana_mux_scan_master
    import ana_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 50,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int ADC_W          = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       scan_mask,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [3:0]       avm_writedata,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic             res_valid,
    output logic [2:0]       res_chan,
    output logic [ADC_W-1:0] res_data,
    output logic             res_err,
    output logic             busy,
    output logic             done
);

    // One timer width covers whichever interval is longer.
    localparam int MAX_CNT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CNT + 1);

    scan_state_e      state_q, state_d;
    logic [7:0]       mask_q, mask_d;
    logic [3:0]       idx_q, idx_d;
    logic [2:0]       ch_q, ch_d;
    logic             aborted_q, aborted_d;

    logic             cs_q, wr_n_q, adc_start_q, res_valid_q, res_err_q, busy_q, done_q;
    logic [3:0]       wdata_q;
    logic [2:0]       res_chan_q;
    logic [ADC_W-1:0] res_data_q;

    logic             settle_load, settle_dec, settle_zero;
    logic [ADC_W-1:0] w_res_data;
    logic             w_res_err;
    logic [3:0]       w_sel;
    logic             w_abort_ok;
    pick_t            w_pick;

`ifdef ANA_SCAN_TIMEOUT_EN
    logic             tmo_load, tmo_dec, tmo_zero;
`endif

    ana_scan_timer #(.W(TMR_W)) u_settle (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (settle_load),
        .load_val_i (TMR_W'(SETTLE_CYCLES - 1)),
        .dec_i      (settle_dec),
        .zero_o     (settle_zero)
    );

`ifdef ANA_SCAN_TIMEOUT_EN
    ana_scan_timer #(.W(TMR_W)) u_timeout (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmo_load),
        .load_val_i (TMR_W'(TIMEOUT_CYCLES - 1)),
        .dec_i      (tmo_dec),
        .zero_o     (tmo_zero)
    );
`endif

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        ch_d        = ch_q;
        aborted_d   = aborted_q;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        w_res_data  = adc_data;
        w_res_err   = 1'b0;
        w_pick      = next_chan(mask_q, idx_q);
        w_abort_ok  = abort && (state_q != S_IDLE) && (state_q != S_DESELECT) && (state_q != S_DONE);
`ifdef ANA_SCAN_TIMEOUT_EN
        tmo_load    = 1'b0;
        tmo_dec     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                aborted_d = 1'b0;
                if (start) begin
                    mask_d  = scan_mask;
                    idx_d   = 4'd0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_pick.found) begin
                    ch_d    = w_pick.ch;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DESELECT;
                end
            end
            S_WRITE: begin
                settle_load = 1'b1;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_zero) begin
`ifdef ANA_SCAN_TIMEOUT_EN
                    tmo_load = 1'b1;
`endif
                    state_d  = S_CONVERT;
                end else begin
                    settle_dec = 1'b1;
                end
            end
            S_CONVERT: begin
                if (adc_done) begin
                    state_d = S_RESULT;
                end
`ifdef ANA_SCAN_TIMEOUT_EN
                else if (tmo_zero) begin
                    w_res_data = '1;
                    w_res_err  = 1'b1;
                    state_d    = S_RESULT;
                end else begin
                    tmo_dec = 1'b1;
                end
`endif
            end
            S_RESULT: begin
                // ch=7 wraps the index to 8, which the picker treats as none left.
                idx_d   = {1'b0, ch_q} + 4'd1;
                state_d = S_SCAN;
            end
            S_DESELECT: state_d = aborted_q ? S_IDLE : S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (w_abort_ok) begin
            aborted_d = 1'b1;
            state_d   = S_DESELECT;
        end

        w_sel             = SEL_DESELECT;
        w_sel[SEL_EN_BIT] = 1'b1;
        w_sel[2:0]        = ch_d;
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            idx_q       <= '0;
            ch_q        <= '0;
            aborted_q   <= 1'b0;
            cs_q        <= 1'b0;
            wr_n_q      <= 1'b1;
            wdata_q     <= SEL_DESELECT;
            adc_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_chan_q  <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            ch_q        <= ch_d;
            aborted_q   <= aborted_d;
            cs_q        <= (state_d == S_WRITE) || (state_d == S_DESELECT);
            wr_n_q      <= !((state_d == S_WRITE) || (state_d == S_DESELECT));
            wdata_q     <= (state_d == S_WRITE) ? w_sel : SEL_DESELECT;
            adc_start_q <= (state_d == S_CONVERT) && (state_q != S_CONVERT);
            res_valid_q <= (state_d == S_RESULT);
            if (state_d == S_RESULT) begin
                res_chan_q <= ch_q;
                res_data_q <= w_res_data;
                res_err_q  <= w_res_err;
            end
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign avm_address    = 2'b00;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wr_n_q;
    assign avm_writedata  = wdata_q;
    assign adc_start      = adc_start_q;
    assign res_valid      = res_valid_q;
    assign res_chan       = res_chan_q;
    assign res_data       = res_data_q;
    assign res_err        = res_err_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

`default_nettype wire

// File: doc/ana_mux_scan_master.md
# ana_mux_scan_master

Avalon-MM write-only master that drives the analog-input mux select PIO for channels 17–24 and sequences one ADC conversion per enabled channel. On `start` it walks an 8-bit channel mask lowest-first. For each enabled channel it writes the select code, waits a settle interval, handshakes one ADC conversion and emits the tagged result. It sits between the Nios-side control registers and the 4-bit select PIO slave, replacing software-timed channel switching.

## Interface
- `SETTLE_CYCLES`, 50: clk cycles between the select write and `adc_start` (1 µs at 50 MHz); legal 1–65535.
- `TIMEOUT_CYCLES`, 1023: clk cycles allowed for `adc_done`; used only when the timeout feature is compiled in.
- `ADC_W`, 12: ADC result width.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a scan.
- `abort` in 1: single-cycle request to abandon the current scan.
- `scan_mask` in 8: bit i enables channel 17+i; latched on accepted `start`.
- `avm_address` out 2: always 0.
- `avm_chipselect` out 1: write strobe qualifier.
- `avm_write_n` out 1: active-low write.
- `avm_writedata` out 4: `{1'b1, ch[2:0]}` selects a channel; `4'h0` deselects.
- `adc_start` out 1: one-cycle conversion request.
- `adc_done` in 1: one-cycle conversion complete; `adc_data` is valid in the same cycle.
- `adc_data` in ADC_W: conversion result.
- `res_valid` out 1: one-cycle result strobe.
- `res_chan` out 3: channel index 0–7, meaning channel 17+index.
- `res_data` out ADC_W: result.
- `res_err` out 1: timeout flag, qualified by `res_valid`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle strobe when a scan completes normally.

## Operation
- States: IDLE, SCAN, WRITE, SETTLE, CONVERT, RESULT, DESELECT, DONE.
- IDLE
  - `start` latches `scan_mask`, clears the index to 0 and goes to SCAN.
  - `start` is ignored in every other state.
- SCAN
  - Finds the lowest set mask bit at or above the index.
  - If one is found: latches it as `ch` and goes to WRITE.
  - If none is found: goes to DESELECT.
- WRITE
  - One cycle with `avm_chipselect`=1, `avm_write_n`=0, `avm_writedata`=`{1,ch}`.
  - Next state is SETTLE.
- SETTLE
  - Counter loads SETTLE_CYCLES-1 on entry and decrements.
  - At 0 it goes to CONVERT.
- CONVERT
  - `adc_start`=1 in the first cycle only.
  - Waits for `adc_done` and captures `adc_data` in the cycle `adc_done` is high.
  - Then goes to RESULT.
- RESULT
  - `res_valid`=1 with `res_chan`=ch.
  - Sets the index to ch+1 and returns to SCAN.
  - When ch=7 the index wraps to 8, which is the "none left" case.
- DESELECT
  - One bus write of `4'h0`.
  - Goes to DONE after a normal completion, or to IDLE after an abort.
- DONE
  - `done`=1 for one cycle, then IDLE.
- `scan_mask`=0: the sequence is IDLE→SCAN→DESELECT→DONE. Only the deselect write occurs and no `adc_start` is issued.
- `abort` in any state other than IDLE, DESELECT or DONE: goes to DESELECT next cycle and `done` is not pulsed.
- `abort` and `adc_done` in the same cycle: abort wins and no result is emitted.
- `adc_done` outside CONVERT is ignored.

## Timing
- Reset values:
  - `avm_chipselect`=0, `avm_write_n`=1, `avm_writedata`=0, `avm_address`=0.
  - `adc_start`=0, `res_valid`=0, `res_chan`=0, `res_data`=0, `res_err`=0.
  - `busy`=0, `done`=0; state is IDLE.
- Reset mid-scan stops immediately and no deselect write is issued. The PIO slave shares `reset_n` and clears itself.
- All outputs are registered.
- `start` (cycle 0) → SCAN in cycle 1 → write strobe in cycle 2.
- `adc_start` is in cycle 3+SETTLE_CYCLES.
- `res_valid` follows the `adc_done` cycle by exactly one cycle.
- Channel-to-channel overhead is 3 cycles (RESULT, SCAN, WRITE) plus SETTLE_CYCLES plus the ADC time.
- The bus write is always exactly one cycle. The slave has no waitrequest.

## Configuration
- `ANA_SCAN_TIMEOUT_EN` defined:
  - In CONVERT, a counter runs from the `adc_start` cycle.
  - After TIMEOUT_CYCLES cycles without `adc_done`, the block enters RESULT with `res_err`=1 and `res_data`=all ones.
  - The scan then continues with the next channel.
- Undefined:
  - CONVERT waits indefinitely; `res_err` is tied to 0 and no timeout counter is synthesized.

## Structure
- `ana_scan_pkg` holds:
  - the state enum;
  - `SEL_EN_BIT`=3;
  - `SEL_DESELECT`=4'h0;
  - `SEL_BASE_CHAN`=17.
- Sub-module `ana_scan_timer`: loadable down-counter with a zero flag. It is instanced for settle, and for timeout when `ANA_SCAN_TIMEOUT_EN` is defined.

## Test plan
- Mask 8'h01, SETTLE_CYCLES=4, ADC replies 5 cycles after `adc_start` with 12'h123:
  - writes 4'h8, then 4'h0;
  - one result with chan 0, data 12'h123;
  - `done` once.
- Mask 8'hA4:
  - writes 4'hA, 4'hD, 4'hF, 4'h0 in order;
  - three results with chans 2, 5, 7.
- Mask 8'h00:
  - single write of 4'h0;
  - no `adc_start`;
  - `done` 3 cycles after `start`.
- `abort` during SETTLE of chan 3:
  - next write is 4'h0;
  - no `res_valid` for chan 3;
  - no `done`;
  - IDLE follows.
- With `ANA_SCAN_TIMEOUT_EN` and TIMEOUT_CYCLES=16, ADC never answers on chan 1 of mask 8'h03:
  - chan 0 result `res_err`=0;
  - chan 1 result `res_err`=1, data 12'hFFF;
  - `done` still pulses.
- Assert `reset_n` in CONVERT:
  - all outputs return to reset values within the same cycle;
  - a `start` after release runs a full scan normally.
